shift_mult_pool: RTL and testbench

- Pool of NUM_MULT independent, signed, radix-2 shift-add multipliers.
- Sits directly downstream of the node/multiplier arbiter: consumes its per-multiplier start pulses and returns busy status, so the arbiter only grants idle units.
- Each unit carries the requesting node's tag through the computation and presents tagged results with a valid/ready handshake back to the nodes.

---
 rtl/shift_mult_pool.sv | 97 +++++++++
 tb/tb_shift_mult_pool.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/shift_mult_pool.sv
// shift_mult_pool: pool of independent signed radix-2 shift-add multipliers with tagged valid/ready results
module shift_mult_pool #(
    parameter int NUM_NODES = 10,
    parameter int NUM_MULT  = 10,
    parameter int DATA_W    = 16,
    localparam int TAG_W    = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
    localparam int CNT_W    = $clog2(NUM_MULT + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic [NUM_MULT-1:0]          start_i,
    input  logic [NUM_MULT*DATA_W-1:0]   op_a_i,
    input  logic [NUM_MULT*DATA_W-1:0]   op_b_i,
    input  logic [NUM_MULT*TAG_W-1:0]    tag_i,
    output logic [NUM_MULT-1:0]          busy_o,
    output logic [NUM_MULT-1:0]          result_valid_o,
    input  logic [NUM_MULT-1:0]          result_ready_i,
    output logic [NUM_MULT*2*DATA_W-1:0] result_o,
    output logic [NUM_MULT*TAG_W-1:0]    result_tag_o,
    output logic [CNT_W-1:0]             busy_count_o
);
    localparam int BIT_W = $clog2(DATA_W + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    logic [NUM_MULT-1:0] busy_n;
    logic [CNT_W-1:0]    count_n;
    genvar g;
    generate
        for (g = 0; g < NUM_MULT; g++) begin : g_unit
            state_t              state, state_n;
            logic [2*DATA_W-1:0] mcand, acc, res;
            logic [DATA_W:0]     mplier, mag_a, mag_b;
            logic [BIT_W-1:0]    cnt;
            logic                sign, last;
            logic [TAG_W-1:0]    tag;
            logic [DATA_W-1:0]   a, b;
            assign a     = op_a_i[g*DATA_W +: DATA_W];
            assign b     = op_b_i[g*DATA_W +: DATA_W];
            assign mag_a = a[DATA_W-1] ? -{a[DATA_W-1], a} : {a[DATA_W-1], a};
            assign mag_b = b[DATA_W-1] ? -{b[DATA_W-1], b} : {b[DATA_W-1], b};
            assign last  = cnt == BIT_W'(DATA_W);
            // state register
            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) state <= IDLE;
                else state <= state_n;
            end
            // next state: one extra CALC edge after the last iteration loads the sign-corrected result
            always_comb begin
                state_n = (state == IDLE && start_i[g])        ? CALC :
                          (state == CALC && last)              ? DONE :
                          (state == DONE && result_ready_i[g]) ? IDLE : state;
            end
            // operand capture and shift-add datapath
            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    mcand  <= '0;
                    mplier <= '0;
                    acc    <= '0;
                    res    <= '0;
                    cnt    <= '0;
                    sign   <= 1'b0;
                    tag    <= '0;
                end else if (state == IDLE && start_i[g]) begin
                    mcand  <= {{(DATA_W-1){1'b0}}, mag_a};
                    mplier <= mag_b;
                    sign   <= a[DATA_W-1] ^ b[DATA_W-1];
                    tag    <= tag_i[g*TAG_W +: TAG_W];
                    acc    <= '0;
                    cnt    <= '0;
                end else if (state == CALC) begin
                    if (last) begin
                        res <= sign ? -acc : acc;
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                    end
                end
            end
            assign busy_n[g]         = state_n != IDLE;
            assign busy_o[g]         = state != IDLE;
            assign result_valid_o[g] = state == DONE;
            assign result_o[g*2*DATA_W +: 2*DATA_W] = res;
            assign result_tag_o[g*TAG_W +: TAG_W]   = tag;
        end
    endgenerate
    // population count of next-state busy bits
    always_comb begin
        count_n = '0;
        for (int i = 0; i < NUM_MULT; i++) count_n = count_n + CNT_W'(busy_n[i]);
    end
    // registered so the count lines up with busy_o
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) busy_count_o <= '0;
        else busy_count_o <= count_n;
    end
endmodule

// File: tb/tb_shift_mult_pool.sv
// tb_shift_mult_pool: directed self-checking bench for shift_mult_pool
module tb_shift_mult_pool;
    localparam int NM = 10, DW = 16, TW = 4, CW = 4;
    logic            clk_i = 1'b0, reset_ni = 1'b0;
    logic [NM-1:0]   start_i = '0, result_ready_i = '0;
    logic [NM*DW-1:0] op_a_i = '0, op_b_i = '0;
    logic [NM*TW-1:0] tag_i = '0;
    logic [NM-1:0]   busy_o, result_valid_o;
    logic [NM*2*DW-1:0] result_o;
    logic [NM*TW-1:0] result_tag_o;
    logic [CW-1:0]   busy_count_o;
    int checks = 0, failures = 0;
    logic [31:0] exp4 [10] = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd0, 32'd40, 32'd100,
                               32'd180, 32'd280, 32'd400, 32'd540, 32'd700};

    shift_mult_pool dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .op_a_i(op_a_i),
        .op_b_i(op_b_i), .tag_i(tag_i), .busy_o(busy_o), .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i), .result_o(result_o), .result_tag_o(result_tag_o),
        .busy_count_o(busy_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input int u, input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
        op_a_i[u*DW +: DW] = a;
        op_b_i[u*DW +: DW] = b;
        tag_i[u*TW +: TW]  = t;
        start_i[u] = 1'b1;
    endtask

    task automatic wait_valid(input int u, output int lat);
        lat = 0;
        while (!result_valid_o[u] && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic job(input string nm, input int u, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] t, input logic [31:0] exp);
        int lat;
        load(u, a, b, t);
        tick();
        start_i = '0;
        check({nm, "_busy"}, 64'(busy_o[u]), 64'd1);
        check({nm, "_cnt_run"}, 64'(busy_count_o), 64'd1);
        wait_valid(u, lat);
        check({nm, "_lat"}, 64'(lat), 64'd17);
        check({nm, "_res"}, 64'(result_o[u*2*DW +: 2*DW]), 64'(exp));
        check({nm, "_tag"}, 64'(result_tag_o[u*TW +: TW]), 64'(t));
        check({nm, "_cnt_done"}, 64'(busy_count_o), 64'd1);
        result_ready_i[u] = 1'b1;
        tick();
        result_ready_i[u] = 1'b0;
        check({nm, "_drop"}, 64'({busy_o[u], result_valid_o[u]}), 64'd0);
        check({nm, "_cnt_idle"}, 64'(busy_count_o), 64'd0);
        check({nm, "_hold"}, 64'(result_o[u*2*DW +: 2*DW]), 64'(exp));
    endtask

    initial begin
        int lat;
        #12;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_valid", 64'(result_valid_o), 64'd0);
        check("rst_res", 64'(|result_o), 64'd0);
        check("rst_cnt", 64'(busy_count_o), 64'd0);
        reset_ni = 1'b1;
        tick();

        job("basic", 0, 16'd3, -16'sd7, 4'd5, 32'hFFFFFFEB);
        job("minmin", 1, 16'h8000, 16'h8000, 4'd1, 32'h40000000);
        job("minmax", 1, 16'h8000, 16'h7FFF, 4'd2, 32'hC0008000);
        job("zero", 1, 16'd0, 16'hFFFF, 4'd3, 32'd0);

        load(2, 16'd100, -16'sd3, 4'd7);
        tick();
        start_i = '0;
        wait_valid(2, lat);
        check("bp_lat", 64'(lat), 64'd17);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) load(2, 16'd9, 16'd9, 4'd2);
            tick();
            start_i = '0;
        end
        check("bp_valid", 64'(result_valid_o[2]), 64'd1);
        check("bp_busy", 64'(busy_o[2]), 64'd1);
        check("bp_res", 64'(result_o[2*2*DW +: 2*DW]), 64'hFFFFFED4);
        check("bp_tag", 64'(result_tag_o[2*TW +: TW]), 64'd7);
        result_ready_i[2] = 1'b1;
        tick();
        result_ready_i[2] = 1'b0;
        check("bp_drop", 64'({busy_o[2], result_valid_o[2]}), 64'd0);
        repeat (3) tick();
        check("bp_no_restart", 64'(busy_o[2]), 64'd0);

        for (int u = 0; u < NM; u++) load(u, 16'(u + 1), 16'(10 * u - 20), 4'(9 - u));
        tick();
        start_i = '0;
        check("par_cnt", 64'(busy_count_o), 64'd10);
        repeat (16) tick();
        check("par_early", 64'(result_valid_o), 64'd0);
        tick();
        check("par_valid", 64'(result_valid_o), 64'h3FF);
        for (int u = 0; u < NM; u++) begin
            check($sformatf("par_res%0d", u), 64'(result_o[u*2*DW +: 2*DW]), 64'(exp4[u]));
            check($sformatf("par_tag%0d", u), 64'(result_tag_o[u*TW +: TW]), 64'(9 - u));
            result_ready_i[u] = 1'b1;
            tick();
            result_ready_i[u] = 1'b0;
            check($sformatf("par_step%0d", u), 64'(busy_count_o), 64'(9 - u));
        end

        load(3, 16'd1000, 16'd1000, 4'd4);
        tick();
        start_i = '0;
        repeat (5) tick();
        reset_ni = 1'b0;
        #1;
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_valid", 64'(result_valid_o), 64'd0);
        check("arst_res", 64'(|result_o), 64'd0);
        check("arst_cnt", 64'(busy_count_o), 64'd0);
        #2;
        reset_ni = 1'b1;
        tick();
        job("post_rst", 3, 16'd2, 16'd2, 4'd6, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
